// File: rtl/kmeans_centroid_update_k3_d3.sv
// kmeans_centroid_update_k3_d3
// Consumer end of the k-means assignment pipeline (K=3 centroids, D=3 dims).
// Accumulates per-centroid coordinate sums and point counts over an epoch,
// then divides sum by count with restoring dividers and presents the new
// centroids for the next iteration.
//
// Ports
//   clk, rst                   clock (posedge), synchronous active-high reset
//   start                      begin epoch, honoured only in IDLE
//   in_valid/in_last/in_ready  point handshake; in_last marks the epoch's end
//   input_data0..2             point coordinates (unsigned)
//   selected_centroid          centroid index 0..2 (3 is illegal)
//   centroidK_dD               current centroids, used for empty clusters
//   new_centroidK_dD           updated centroids, held between out_valid pulses
//   out_valid                  1-cycle pulse when new_centroid* are updated
//   busy                       high in any state other than IDLE
//   err                        sticky: illegal index or count saturation
//
// Division: the three dimensions of a cluster share the divisor (the count),
// so they are divided in parallel, one quotient bit per cycle, MSB first.
// Each non-empty cluster costs SW cycles of iteration; every element still
// takes one DIV_LOAD visit, which gives a latency of 10 + SW*Nne cycles from
// the in_last acceptance edge to out_valid.
module kmeans_centroid_update_k3_d3 #(
  parameter int input_data_width = 16,
  parameter int count_width      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic [input_data_width-1:0] input_data0,
  input  logic [input_data_width-1:0] input_data1,
  input  logic [input_data_width-1:0] input_data2,
  input  logic [1:0]                  selected_centroid,
  input  logic [input_data_width-1:0] centroid0_d0,
  input  logic [input_data_width-1:0] centroid0_d1,
  input  logic [input_data_width-1:0] centroid0_d2,
  input  logic [input_data_width-1:0] centroid1_d0,
  input  logic [input_data_width-1:0] centroid1_d1,
  input  logic [input_data_width-1:0] centroid1_d2,
  input  logic [input_data_width-1:0] centroid2_d0,
  input  logic [input_data_width-1:0] centroid2_d1,
  input  logic [input_data_width-1:0] centroid2_d2,
  output logic [input_data_width-1:0] new_centroid0_d0,
  output logic [input_data_width-1:0] new_centroid0_d1,
  output logic [input_data_width-1:0] new_centroid0_d2,
  output logic [input_data_width-1:0] new_centroid1_d0,
  output logic [input_data_width-1:0] new_centroid1_d1,
  output logic [input_data_width-1:0] new_centroid1_d2,
  output logic [input_data_width-1:0] new_centroid2_d0,
  output logic [input_data_width-1:0] new_centroid2_d1,
  output logic [input_data_width-1:0] new_centroid2_d2,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        err
);

  localparam int DW  = input_data_width;
  localparam int CW  = count_width;
  localparam int SW  = DW + CW;
  localparam int ITW = $clog2(SW);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIV_LOAD, S_DIV_ITER, S_DONE} state_t;

  state_t r_state, w_state_nx;

  logic [SW-1:0] r_sum [3][3];
  logic [CW-1:0] r_cnt [3];
  logic [DW-1:0] r_new [3][3];
  logic [SW-1:0] r_dvd [3];   // dividend, shifted left; quotient bits enter at LSB
  logic [CW-1:0] r_rem [3];
  logic [ITW-1:0] r_iter;
  logic [1:0]    r_k, r_d;    // element being finalised
  logic          r_out_valid, r_err;

  logic [DW-1:0] w_point [3];
  logic [DW-1:0] w_cent  [3][3];
  logic [CW-1:0] w_sel_cnt;
  logic          w_legal, w_sat, w_empty, w_iter_last, w_elem_last, w_advance;
  logic [CW:0]   w_trial [3];
  logic [CW:0]   w_diff  [3];
  logic          w_qbit  [3];
  logic [CW-1:0] w_rem_nx [3];
  logic [SW-1:0] w_dvd_nx [3];

  assign w_point = '{input_data0, input_data1, input_data2};
  assign w_cent  = '{'{centroid0_d0, centroid0_d1, centroid0_d2},
                     '{centroid1_d0, centroid1_d1, centroid1_d2},
                     '{centroid2_d0, centroid2_d1, centroid2_d2}};

  assign {new_centroid0_d0, new_centroid0_d1, new_centroid0_d2} = {r_new[0][0], r_new[0][1], r_new[0][2]};
  assign {new_centroid1_d0, new_centroid1_d1, new_centroid1_d2} = {r_new[1][0], r_new[1][1], r_new[1][2]};
  assign {new_centroid2_d0, new_centroid2_d1, new_centroid2_d2} = {r_new[2][0], r_new[2][1], r_new[2][2]};
  assign out_valid = r_out_valid;
  assign err       = r_err;

  assign w_legal     = (selected_centroid != 2'd3);
  assign w_sat       = w_legal && (w_sel_cnt == '1);
  assign w_empty     = (r_cnt[r_k] == '0);
  assign w_iter_last = (r_iter == ITW'(SW - 1));
  assign w_elem_last = (r_k == 2'd2) && (r_d == 2'd2);
  // Elements d1/d2 of a non-empty cluster were written by the d0 division.
  assign w_advance   = ((r_state == S_DIV_LOAD) && (w_empty || (r_d != 2'd0))) ||
                       ((r_state == S_DIV_ITER) && w_iter_last);

  // One restoring step per dimension: since r_rem < divisor, the difference
  // borrows (MSB set) exactly when the trial remainder is below the divisor.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_sel_cnt = '0;
    if (w_legal) w_sel_cnt = r_cnt[selected_centroid];
    for (int d = 0; d < 3; d++) begin
      w_trial[d]  = {r_rem[d], r_dvd[d][SW-1]};
      w_diff[d]   = w_trial[d] - {1'b0, r_cnt[r_k]};
      w_qbit[d]   = ~w_diff[d][CW];
      w_rem_nx[d] = w_qbit[d] ? w_diff[d][CW-1:0] : w_trial[d][CW-1:0];
      w_dvd_nx[d] = {r_dvd[d][SW-2:0], w_qbit[d]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_nx = S_DIV_LOAD;
      end
      S_DIV_LOAD: begin
        if (!w_advance)      w_state_nx = S_DIV_ITER;
        else if (w_elem_last) w_state_nx = S_DONE;
      end
      S_DIV_ITER: begin
        if (w_iter_last) w_state_nx = w_elem_last ? S_DONE : S_DIV_LOAD;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these arrays are small register banks, not RAM, so resetting them is cheap and required.
      for (int k = 0; k < 3; k++) begin
        r_cnt[k] <= '0;
        r_dvd[k] <= '0;
        r_rem[k] <= '0;
        for (int d = 0; d < 3; d++) begin
          r_sum[k][d] <= '0;
          r_new[k][d] <= '0;
        end
      end
      r_iter      <= '0;
      r_k         <= '0;
      r_d         <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < 3; k++) begin
              r_cnt[k] <= '0;
              for (int d = 0; d < 3; d++) r_sum[k][d] <= '0;
            end
            r_err <= 1'b0;
            r_k   <= '0;
            r_d   <= '0;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            // Illegal or saturated points are consumed but leave sums and
            // counts untouched, keeping every sum consistent with its count.
            if (!w_legal || w_sat) begin
              r_err <= 1'b1;
            end else begin
              r_cnt[selected_centroid] <= r_cnt[selected_centroid] + CW'(1);
              for (int d = 0; d < 3; d++)
                r_sum[selected_centroid][d] <= r_sum[selected_centroid][d] + SW'(w_point[d]);
            end
          end
        end
        S_DIV_LOAD: begin
          if (w_empty) begin
            r_new[r_k][r_d] <= w_cent[r_k][r_d];
          end else if (r_d == 2'd0) begin
            for (int d = 0; d < 3; d++) begin
              r_dvd[d] <= r_sum[r_k][d];
              r_rem[d] <= '0;
            end
            r_iter <= '0;
          end
        end
        S_DIV_ITER: begin
          r_iter <= r_iter + ITW'(1);
          for (int d = 0; d < 3; d++) begin
            r_dvd[d] <= w_dvd_nx[d];
            r_rem[d] <= w_rem_nx[d];
            // The quotient is an average, so its upper bits are always zero.
            if (w_iter_last) r_new[r_k][d] <= w_dvd_nx[d][DW-1:0];
          end
        end
        default: ;
      endcase
      if (w_advance) begin
        if (r_d == 2'd2) begin
          r_d <= '0;
          r_k <= r_k + 2'd1;
        end else begin
          r_d <= r_d + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d3.sv
module tb_kmeans_centroid_update_k3_d3;

  localparam int SW = 32;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic        in_ready, out_valid, busy, err;
  logic [15:0] din [3];
  logic [1:0]  sel;
  logic [15:0] cent [3][3];
  logic [15:0] nc   [3][3];

  always #5 clk = ~clk;

  kmeans_centroid_update_k3_d3 dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .input_data0(din[0]), .input_data1(din[1]), .input_data2(din[2]),
    .selected_centroid(sel),
    .centroid0_d0(cent[0][0]), .centroid0_d1(cent[0][1]), .centroid0_d2(cent[0][2]),
    .centroid1_d0(cent[1][0]), .centroid1_d1(cent[1][1]), .centroid1_d2(cent[1][2]),
    .centroid2_d0(cent[2][0]), .centroid2_d1(cent[2][1]), .centroid2_d2(cent[2][2]),
    .new_centroid0_d0(nc[0][0]), .new_centroid0_d1(nc[0][1]), .new_centroid0_d2(nc[0][2]),
    .new_centroid1_d0(nc[1][0]), .new_centroid1_d1(nc[1][1]), .new_centroid1_d2(nc[1][2]),
    .new_centroid2_d0(nc[2][0]), .new_centroid2_d1(nc[2][1]), .new_centroid2_d2(nc[2][2]),
    .out_valid(out_valid), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [2:0][15:0] d;
    logic [1:0]       sel;
  } point_t;

  point_t      pts [$];
  logic [15:0] exp_c [3][3];
  logic        exp_err;
  int          exp_lat;

  // Reference: plain per-cluster averages over the epoch's legal points.
  task automatic model();
    longint s [3][3];
    int     c [3];
    int     nne = 0;
    exp_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c[k] = 0;
      for (int d = 0; d < 3; d++) s[k][d] = 0;
    end
    foreach (pts[i]) begin
      if (pts[i].sel == 2'd3) exp_err = 1'b1;
      else begin
        c[pts[i].sel]++;
        for (int d = 0; d < 3; d++) s[pts[i].sel][d] += longint'(pts[i].d[d]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (c[k] != 0) nne++;
      for (int d = 0; d < 3; d++)
        exp_c[k][d] = (c[k] == 0) ? cent[k][d] : 16'(s[k][d] / longint'(c[k]));
    end
    exp_lat = 10 + SW * nne;
  endtask

  task automatic add_pt(input int a, input int b, input int c, input int k);
    point_t p;
    p.d[0] = 16'(a); p.d[1] = 16'(b); p.d[2] = 16'(c); p.sel = 2'(k);
    pts.push_back(p);
  endtask

  // Start an epoch and stream the queued points, with random idle gaps.
  task automatic feed();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    foreach (pts[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      for (int d = 0; d < 3; d++) din[d] = pts[i].d[d];
      sel     = pts[i].sel;
      in_last = (i == pts.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic run_epoch(input string name, input bit noise);
    bit got = 0;
    int cyc;
    model();
    feed();
    check({name, "_busy"}, busy, 1);
    check({name, "_in_ready_div"}, in_ready, 0);
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1;
        break;
      end
      if (noise) begin
        start    = (cyc < 40);
        in_valid = 1'b1;
        in_last  = 1'b1;
        sel      = 2'($urandom_range(0, 2));
        for (int d = 0; d < 3; d++) din[d] = 16'($urandom_range(0, 65535));
      end
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check({name, "_latency"}, got ? cyc : -1, exp_lat);
    for (int k = 0; k < 3; k++)
      for (int d = 0; d < 3; d++)
        check($sformatf("%s_k%0dd%0d", name, k, d), nc[k][d], exp_c[k][d]);
    check({name, "_err"}, err, exp_err);
    check({name, "_busy_after"}, busy, 0);
    @(posedge clk); #1;
    check({name, "_pulse_width"}, out_valid, 0);
  endtask

  task automatic load_basic();
    pts.delete();
    add_pt(10, 20, 30, 0);
    add_pt(20, 40, 60, 0);
    add_pt(30, 60, 90, 0);
    add_pt(5, 5, 5, 1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; sel = '0;
    for (int d = 0; d < 3; d++) din[d] = '0;
    cent = '{'{16'd100, 16'd200, 16'd300}, '{16'd11, 16'd12, 16'd13}, '{16'd7, 16'd8, 16'd9}};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 3; k++)
      for (int d = 0; d < 3; d++) check($sformatf("rst_k%0dd%0d", k, d), nc[k][d], 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_err", err, 0);

    // Basic epoch: k0 average, k1 single point, k2 empty keeps (7,8,9).
    load_basic();
    run_epoch("basic", 0);

    // Truncating division.
    pts.delete();
    add_pt(1, 3, 65535, 0);
    add_pt(2, 4, 65535, 0);
    add_pt(40, 50, 60, 1);
    add_pt(65535, 0, 1, 2);
    run_epoch("trunc", 0);

    // Illegal index between legal points: same averages, err set.
    load_basic();
    pts.insert(2, '{d: {16'd999, 16'd999, 16'd999}, sel: 2'd3});
    run_epoch("illegal", 0);

    // in_valid and start held during division must not disturb the result.
    load_basic();
    run_epoch("noise", 1);

    // Reset mid-division: outputs return to zero and no out_valid follows.
    load_basic();
    feed();
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_err", err, 0);
    check("midrst_k0d0", nc[0][0], 0);
    check("midrst_k1d2", nc[1][2], 0);
    check("midrst_k2d1", nc[2][1], 0);
    seen = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_out_valid", seen, 0);
    load_basic();
    run_epoch("after_rst", 0);

    // Randomized epochs against the reference averages.
    for (int e = 0; e < 5; e++) begin
      pts.delete();
      for (int k = 0; k < 3; k++)
        for (int d = 0; d < 3; d++) cent[k][d] = 16'($urandom_range(0, 65535));
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
        int k;
        k = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        if (e == 1) k = (k == 3) ? 3 : 0;
        add_pt(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
               int'($urandom_range(60000, 65535)), k);
      end
      run_epoch($sformatf("rand%0d", e), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
